// File: rtl/router_pkg.sv
// -----------------------------------------------------------------------------
// router_pkg
//   Shared types, defaults and helpers for the router datapath selector.
//   - DATA_W_DEF / NUM_PORTS_DEF : default word width and port count
//   - MAX_PORTS / MAX_ADDR_W     : upper bound on port count (16) and its address width
//   - port_state_t               : per-port output register state
//   - port_sel_t / port_sel()    : destination mask (one-hot or all-ones) + invalid flag
// -----------------------------------------------------------------------------
package router_pkg;

   localparam int unsigned DATA_W_DEF    = 32;
   localparam int unsigned NUM_PORTS_DEF = 8;
   localparam int unsigned MAX_PORTS     = 16;
   localparam int unsigned MAX_ADDR_W    = 4;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } port_state_t;

   typedef struct packed {
      logic [MAX_PORTS-1:0] mask;
      logic                 invalid;
   } port_sel_t;

   // Mask is sized for the largest supported router; callers keep the low
   // num_ports bits. invalid is only raised for unicast to a missing port.
   function automatic port_sel_t port_sel(input logic [MAX_ADDR_W-1:0] addr,
                                          input logic                  bcast,
                                          input int unsigned           num_ports);
      port_sel_t sel;
      sel.mask    = '0;
      sel.invalid = 1'b0;
      if (bcast) begin
         sel.mask = MAX_PORTS'((32'd1 << num_ports) - 32'd1);
      end else if (32'(addr) < num_ports) begin
         sel.mask = MAX_PORTS'(32'd1 << addr);
      end else begin
         sel.invalid = 1'b1;
      end
      return sel;
   endfunction

endpackage

// File: rtl/selector_port_reg.sv
// -----------------------------------------------------------------------------
// selector_port_reg
//   One-word output register for a single selector port with valid/ready
//   handshake. A load and a drain in the same cycle replace the held word
//   without a bubble.
//   Ports:
//     clk, reset_n : clock, asynchronous active-low reset
//     load         : write load_data this cycle (only asserted while free)
//     load_data    : word to capture
//     out_ready    : downstream sink ready
//     out_valid    : register holds a word
//     out_data     : held word (keeps last value after a drain)
//     free         : register can accept a load this cycle
// -----------------------------------------------------------------------------
module selector_port_reg
   import router_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              load,
   input  logic [DATA_W-1:0] load_data,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              free
);

   port_state_t       state;
   port_state_t       state_nxt;
   logic [DATA_W-1:0] data_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      out_valid = (state == FULL);
      free      = (state == EMPTY) | out_ready;
      if (load) begin
         state_nxt = FULL;
      end else if ((state == FULL) && out_ready) begin
         state_nxt = EMPTY;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_q <= '0;
      end else if (load) begin
         data_q <= load_data;
      end
   end

   assign out_data = data_q;

endmodule

// File: rtl/route_selector.sv
// -----------------------------------------------------------------------------
// route_selector
//   Registered 1-to-NUM_PORTS selector between the input parser and the
//   per-port output FIFOs. Each accepted word lands in one port register (or
//   all of them for broadcast) one clock later. Unicast words addressed past
//   the last port are accepted, discarded and counted.
//   Ports:
//     clk, reset_n        : clock, asynchronous active-low reset
//     in_valid / in_ready : input handshake (in_ready is combinational)
//     in_addr             : destination port index
//     in_bcast            : send to every port, in_addr ignored
//     in_data             : input word
//     out_valid/out_ready : per-port handshake
//     out_data            : per-port word, port p at [p*DATA_W +: DATA_W]
//     drop_cnt            : saturating count of discarded words
//     clr_cnt             : synchronous clear of drop_cnt (wins over a drop)
// -----------------------------------------------------------------------------
module route_selector
   import router_pkg::*;
#(
   parameter int unsigned DATA_W    = DATA_W_DEF,
   parameter int unsigned NUM_PORTS = NUM_PORTS_DEF,
   parameter int unsigned ADDR_W    = $clog2(NUM_PORTS),
   parameter int unsigned CNT_W     = 16
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [ADDR_W-1:0]           in_addr,
   input  logic                        in_bcast,
   input  logic [DATA_W-1:0]           in_data,
   output logic [NUM_PORTS-1:0]        out_valid,
   input  logic [NUM_PORTS-1:0]        out_ready,
   output logic [NUM_PORTS*DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]            drop_cnt,
   input  logic                        clr_cnt
);

   port_sel_t            sel;
   logic [NUM_PORTS-1:0] port_mask;
   logic [NUM_PORTS-1:0] port_free;
   logic [NUM_PORTS-1:0] port_load;
   logic                 accept;
   logic                 drop;

   assign sel       = port_sel(MAX_ADDR_W'(in_addr), in_bcast, NUM_PORTS);
   assign port_mask = sel.mask[NUM_PORTS-1:0];

   if (NUM_PORTS < MAX_PORTS) begin : g_mask_hi
      logic unused_mask_hi;
      assign unused_mask_hi = ^sel.mask[MAX_PORTS-1:NUM_PORTS];
   end

   // Broadcast waits for every port so no port ever sees half a broadcast;
   // an invalid unicast address is always accepted so it can be sunk.
   assign in_ready  = sel.invalid | (in_bcast ? (&port_free) : (|(port_mask & port_free)));
   assign accept    = in_valid & in_ready;
   assign port_load = {NUM_PORTS{accept}} & port_mask;
   assign drop      = accept & sel.invalid;

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      selector_port_reg #(
         .DATA_W (DATA_W)
      ) u_port_reg (
         .clk       (clk),
         .reset_n   (reset_n),
         .load      (port_load[p]),
         .load_data (in_data),
         .out_ready (out_ready[p]),
         .out_valid (out_valid[p]),
         .out_data  (out_data[p*DATA_W +: DATA_W]),
         .free      (port_free[p])
      );
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         drop_cnt <= '0;
      end else if (clr_cnt) begin
         drop_cnt <= '0;
      end else if (drop && (drop_cnt != '1)) begin
         drop_cnt <= drop_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_route_selector.sv
module tb_route_selector;

   localparam int NP  = 8;
   localparam int DW  = 32;
   localparam int NP6 = 6;
   localparam int CW6 = 2;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   // 8-port instance
   logic              in_valid, in_ready, in_bcast, clr_cnt;
   logic [2:0]        in_addr;
   logic [DW-1:0]     in_data;
   logic [NP-1:0]     out_valid, out_ready;
   logic [NP*DW-1:0]  out_data;
   logic [15:0]       drop_cnt;

   // 6-port instance with a 2-bit drop counter
   logic              in_valid6, in_ready6, in_bcast6, clr_cnt6;
   logic [2:0]        in_addr6;
   logic [DW-1:0]     in_data6;
   logic [NP6-1:0]    out_valid6, out_ready6;
   logic [NP6*DW-1:0] out_data6;
   logic [CW6-1:0]    drop_cnt6;

   route_selector #(.DATA_W(DW), .NUM_PORTS(NP), .CNT_W(16)) dut8 (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_addr(in_addr), .in_bcast(in_bcast), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .drop_cnt(drop_cnt), .clr_cnt(clr_cnt)
   );

   route_selector #(.DATA_W(DW), .NUM_PORTS(NP6), .CNT_W(CW6)) dut6 (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid6), .in_ready(in_ready6),
      .in_addr(in_addr6), .in_bcast(in_bcast6), .in_data(in_data6),
      .out_valid(out_valid6), .out_ready(out_ready6), .out_data(out_data6),
      .drop_cnt(drop_cnt6), .clr_cnt(clr_cnt6)
   );

   int total = 0;
   int bad   = 0;

   // Reference: what each port currently holds, and the dropped-word tally.
   bit            mv [NP];
   logic [DW-1:0] md [NP];
   int            cnt6;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic model_ready();
      logic r;
      if (in_bcast) begin
         r = 1'b1;
         for (int p = 0; p < NP; p++)
            if (mv[p] && !out_ready[p]) r = 1'b0;
      end else begin
         r = !mv[in_addr] || out_ready[in_addr];
      end
      return r;
   endfunction

   task automatic model_reset();
      for (int p = 0; p < NP; p++) begin
         mv[p] = 1'b0;
         md[p] = '0;
      end
   endtask

   // Entered just after a rising edge with inputs driven; leaves 1ns after the next one.
   task automatic cycle8();
      logic             exp_rdy;
      bit               nv [NP];
      logic [DW-1:0]    nd [NP];
      logic [NP-1:0]    ev;
      logic [NP*DW-1:0] ed;
      #1;
      exp_rdy = model_ready();
      chk("in_ready", {255'b0, in_ready}, {255'b0, exp_rdy});
      for (int p = 0; p < NP; p++) begin
         nv[p] = mv[p];
         nd[p] = md[p];
         if (in_valid && exp_rdy && (in_bcast || int'(in_addr) == p)) begin
            nv[p] = 1'b1;
            nd[p] = in_data;
         end else if (mv[p] && out_ready[p]) begin
            nv[p] = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      for (int p = 0; p < NP; p++) begin
         mv[p] = nv[p];
         md[p] = nd[p];
         ev[p] = mv[p];
         ed[p*DW +: DW] = md[p];
      end
      chk("out_valid", {248'b0, out_valid}, {248'b0, ev});
      chk("out_data", out_data, ed);
      chk("drop_cnt", {240'b0, drop_cnt}, 256'd0);
   endtask

   task automatic cycle6(input logic exp_rdy, input logic [NP6-1:0] exp_v);
      int nc;
      #1;
      chk("in_ready6", {255'b0, in_ready6}, {255'b0, exp_rdy});
      nc = cnt6;
      if (clr_cnt6) nc = 0;
      else if (in_valid6 && !in_bcast6 && int'(in_addr6) >= NP6 && cnt6 < (1 << CW6) - 1)
         nc = cnt6 + 1;
      @(posedge clk);
      #1;
      cnt6 = nc;
      chk("out_valid6", {250'b0, out_valid6}, {250'b0, exp_v});
      chk("drop_cnt6", {254'b0, drop_cnt6}, 256'(cnt6));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      reset_n   = 1'b0;
      in_valid  = 1'b0; in_bcast  = 1'b0; in_addr  = '0; in_data  = '0; clr_cnt  = 1'b0;
      out_ready = '1;
      in_valid6 = 1'b0; in_bcast6 = 1'b0; in_addr6 = '0; in_data6 = '0; clr_cnt6 = 1'b0;
      out_ready6 = '1;
      model_reset();
      cnt6 = 0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", {248'b0, out_valid}, 256'd0);
      chk("rst_data", out_data, 256'd0);
      chk("rst_drop", {240'b0, drop_cnt}, 256'd0);
      chk("rst_valid6", {250'b0, out_valid6}, 256'd0);
      chk("rst_drop6", {254'b0, drop_cnt6}, 256'd0);

      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // idle
      repeat (10) cycle8();

      // unicast and streaming to port 3
      in_valid = 1'b1; in_addr = 3'd3; in_data = 32'hDEADBEEF;
      cycle8();
      chk("ucast_valid", {248'b0, out_valid}, {248'b0, 8'b0000_1000});
      chk("ucast_data", {224'b0, out_data[3*DW +: DW]}, {224'b0, 32'hDEADBEEF});
      for (int i = 0; i < 4; i++) begin
         in_data = 32'h1000_0000 + 32'(i);
         cycle8();
      end
      in_valid = 1'b0;
      cycle8();

      // backpressure on port 5
      out_ready = 8'b1101_1111;
      in_valid = 1'b1; in_addr = 3'd5; in_data = 32'h11;
      cycle8();
      in_data = 32'h22;
      cycle8();
      chk("bp_ready", {255'b0, in_ready}, 256'd0);
      chk("bp_hold", {224'b0, out_data[5*DW +: DW]}, {224'b0, 32'h11});
      out_ready = 8'hFF;
      cycle8();
      chk("bp_reload", {224'b0, out_data[5*DW +: DW]}, {224'b0, 32'h22});
      chk("bp_full", {255'b0, out_valid[5]}, {255'b0, 1'b1});
      in_valid = 1'b0;
      cycle8();

      // broadcast blocked by a stalled full port 2, then released
      out_ready = 8'b1111_1011;
      in_valid = 1'b1; in_addr = 3'd2; in_data = 32'h2222_2222;
      cycle8();
      in_bcast = 1'b1; in_data = 32'hA5A5A5A5;
      cycle8();
      chk("bc_blocked", {224'b0, out_data[2*DW +: DW]}, {224'b0, 32'h2222_2222});
      out_ready = 8'hFF;
      cycle8();
      chk("bc_all_valid", {248'b0, out_valid}, {248'b0, 8'hFF});
      for (int p = 0; p < NP; p++)
         chk("bc_data", {224'b0, out_data[p*DW +: DW]}, {224'b0, 32'hA5A5A5A5});
      in_bcast = 1'b0; in_valid = 1'b0;
      cycle8();

      // random traffic
      repeat (400) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_addr   = 3'($urandom_range(0, 7));
         in_bcast  = ($urandom_range(0, 7) == 0);
         in_data   = $urandom;
         out_ready = 8'($urandom) | 8'($urandom);
         cycle8();
      end

      // async reset with four ports held
      in_valid = 1'b0; in_bcast = 1'b0; out_ready = 8'hFF;
      cycle8();
      out_ready = 8'h00; in_valid = 1'b1;
      for (int a = 0; a < 4; a++) begin
         in_addr = 3'(a);
         in_data = 32'hC0DE_0000 + 32'(a);
         cycle8();
      end
      chk("pre_rst_valid", {248'b0, out_valid}, {248'b0, 8'h0F});
      in_valid = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_valid", {248'b0, out_valid}, 256'd0);
      chk("arst_data", out_data, 256'd0);
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 8'hFF; in_valid = 1'b1; in_addr = 3'd3; in_data = 32'hDEADBEEF;
      cycle8();
      chk("post_rst_valid", {248'b0, out_valid}, {248'b0, 8'b0000_1000});
      chk("post_rst_data", {224'b0, out_data[3*DW +: DW]}, {224'b0, 32'hDEADBEEF});
      in_valid = 1'b0;
      cycle8();

      // invalid addresses on the 6-port instance
      cnt6 = 0;
      in_valid6 = 1'b1; in_addr6 = 3'd7; in_data6 = 32'hBAD0_0007;
      repeat (3) cycle6(1'b1, 6'b0);
      chk("drop3", {254'b0, drop_cnt6}, 256'd3);
      clr_cnt6 = 1'b1;
      cycle6(1'b1, 6'b0);
      chk("clr_wins", {254'b0, drop_cnt6}, 256'd0);
      clr_cnt6 = 1'b0; in_addr6 = 3'd6;
      repeat (5) cycle6(1'b1, 6'b0);
      chk("drop_sat", {254'b0, drop_cnt6}, 256'd3);
      in_addr6 = 3'd5; in_data6 = 32'h5A5A_0005;
      cycle6(1'b1, 6'b10_0000);
      chk("p6_data", {224'b0, out_data6[5*DW +: DW]}, {224'b0, 32'h5A5A_0005});
      in_valid6 = 1'b0;
      cycle6(1'b1, 6'b0);
      clr_cnt6 = 1'b1;
      cycle6(1'b1, 6'b0);
      chk("clr_only", {254'b0, drop_cnt6}, 256'd0);
      clr_cnt6 = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
